// File: rtl/dmem_port_arbiter.sv
// Load/store arbiter for the single-port data memory: picks one requester,
// registers the memory command and times the synchronous read-return window.
module dmem_port_arbiter #(
  parameter int READ_LAT = 1,
  parameter bit RR_EN    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        ld_req,
  input  logic [9:0]  ld_addr,
  output logic        ld_gnt,
  output logic [31:0] ld_rdata,
  output logic        ld_rvalid,
  input  logic        st_req,
  input  logic [9:0]  st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_byte_en,
  output logic        st_gnt,
  output logic        mem_rw_mode,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        last_st_q, last_st_d;
  logic        ld_gnt_q, ld_gnt_d;
  logic        st_gnt_q, st_gnt_d;
  logic        mem_rw_q, mem_rw_d;
  logic [9:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        busy_q, busy_d;
  logic        pick_st_s, pick_ld_s;
  logic        rvalid_s;

  // Arbitration, next-state and next registered memory command.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_st_d   = last_st_q;
    ld_gnt_d    = 1'b0;
    st_gnt_d    = 1'b0;
    mem_rw_d    = 1'b0;
    mem_addr_d  = 10'd0;
    mem_wdata_d = 32'd0;
    mem_be_d    = 4'd0;
    pick_st_s   = 1'b0;
    pick_ld_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_req && st_req) begin
          // last_st_q high means the store side won last, so load goes next.
          if (RR_EN) begin
            pick_st_s = ~last_st_q;
          end else begin
            pick_st_s = 1'b1;
          end
          pick_ld_s = ~pick_st_s;
        end else begin
          pick_st_s = st_req;
          pick_ld_s = ld_req;
        end
        if (pick_st_s) begin
          state_d     = ISSUE;
          st_gnt_d    = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = st_addr;
          mem_wdata_d = st_wdata;
          mem_be_d    = st_byte_en;
          last_st_d   = 1'b1;
        end else if (pick_ld_s) begin
          state_d    = ISSUE;
          ld_gnt_d   = 1'b1;
          mem_addr_d = ld_addr;
          mem_be_d   = 4'b1111;
          last_st_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (ld_gnt_q) begin
          state_d    = WAIT;
          cnt_d      = LAT_M1;
          mem_addr_d = mem_addr_q;
          mem_be_d   = mem_be_q;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d      = cnt_q - 2'd1;
          mem_addr_d = mem_addr_q;
          mem_be_d   = mem_be_q;
        end else begin
          cnt_d   = 2'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, arbitration history and registered memory-side outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      last_st_q   <= 1'b1;
      ld_gnt_q    <= 1'b0;
      st_gnt_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= 10'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_st_q   <= last_st_d;
      ld_gnt_q    <= ld_gnt_d;
      st_gnt_q    <= st_gnt_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      busy_q      <= busy_d;
    end
  end

  // Read return passes straight from the macro in the last WAIT cycle.
  always_comb begin
    rvalid_s = (state_q == WAIT) && (cnt_q == 2'd0);
    if (rvalid_s) begin
      ld_rdata = mem_read_data;
    end else begin
      ld_rdata = 32'd0;
    end
  end

  assign ld_rvalid      = rvalid_s;
  assign ld_gnt         = ld_gnt_q;
  assign st_gnt         = st_gnt_q;
  assign mem_rw_mode    = mem_rw_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_byte_en    = mem_be_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: round-robin arbiter (READ_LAT=2) plus a fixed-priority copy,
// with a byte-lane memory model behind the round-robin instance.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        ld_req = 1'b0;
  logic [9:0]  ld_addr = 10'd0;
  logic        st_req = 1'b0;
  logic [9:0]  st_addr = 10'd0;
  logic [31:0] st_wdata = 32'd0;
  logic [3:0]  st_byte_en = 4'd0;
  logic [31:0] mem_read_data;

  logic        ld_gnt, ld_rvalid, st_gnt, mem_rw_mode, busy;
  logic [31:0] ld_rdata, mem_write_data;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_byte_en;

  logic        fp_ld_gnt, fp_ld_rvalid, fp_st_gnt, fp_mem_rw_mode, fp_busy;
  logic [31:0] fp_ld_rdata, fp_mem_write_data;
  logic [9:0]  fp_mem_addr;
  logic [3:0]  fp_mem_byte_en;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.READ_LAT(2), .RR_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
    .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_byte_en(st_byte_en), .st_gnt(st_gnt),
    .mem_rw_mode(mem_rw_mode), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_byte_en(mem_byte_en),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  dmem_port_arbiter #(.READ_LAT(2), .RR_EN(1'b0)) dut_fp (
    .i_clk(clk), .i_rst(i_rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(fp_ld_gnt),
    .ld_rdata(fp_ld_rdata), .ld_rvalid(fp_ld_rvalid),
    .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata),
    .st_byte_en(st_byte_en), .st_gnt(fp_st_gnt),
    .mem_rw_mode(fp_mem_rw_mode), .mem_addr(fp_mem_addr),
    .mem_write_data(fp_mem_write_data), .mem_byte_en(fp_mem_byte_en),
    .mem_read_data(mem_read_data), .busy(fp_busy)
  );

  // Memory model: byte-lane writes, two-stage read pipe (READ_LAT=2).
  logic [31:0] mem [0:1023];
  logic [31:0] rd_p0, rd_p1;
  always @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      rd_p0 <= 32'd0;
      rd_p1 <= 32'd0;
    end else begin
      if (mem_rw_mode) begin
        for (int b = 0; b < 4; b++)
          if (mem_byte_en[b]) mem[mem_addr][b*8 +: 8] <= mem_write_data[b*8 +: 8];
      end
      rd_p0 <= mem[mem_addr];
      rd_p1 <= rd_p0;
    end
  end
  assign mem_read_data = rd_p1;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    repeat (n) next_cycle();
    i_rst = 1'b1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!busy && !fp_busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL wait_idle: busy=%b fp_busy=%b still high after 30 cycles", busy, fp_busy);
    end
    next_cycle();
  endtask

  task automatic store_raw(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    bit ok = 1'b0;
    st_req = 1'b1; st_addr = a; st_wdata = d; st_byte_en = be;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (st_gnt) begin ok = 1'b1; break; end
      next_cycle();
    end
    if (!ok) begin errors++; checks++; $display("FAIL store_raw_gnt: no st_gnt within 20 cycles"); end
    next_cycle();
    st_req = 1'b0;
    wait_idle();
  endtask

  task automatic load_raw(input logic [9:0] a, output logic [31:0] d);
    bit ok = 1'b0;
    d = 32'd0;
    ld_req = 1'b1; ld_addr = a;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ld_gnt) begin ok = 1'b1; break; end
      next_cycle();
    end
    if (!ok) begin errors++; checks++; $display("FAIL load_raw_gnt: no ld_gnt within 20 cycles"); end
    next_cycle();
    ld_req = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ld_rvalid) begin ok = 1'b1; d = ld_rdata; break; end
      next_cycle();
    end
    if (!ok) begin errors++; checks++; $display("FAIL load_raw_rvalid: no ld_rvalid within 10 cycles"); end
    wait_idle();
  endtask

  task automatic test_reset();
    i_rst = 1'b0; ld_req = 1'b1; st_req = 1'b1;
    ld_addr = 10'h02A; st_addr = 10'h015; st_wdata = 32'h1111_2222; st_byte_en = 4'hF;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if ({ld_gnt, st_gnt, ld_rvalid, mem_rw_mode, busy, mem_addr, mem_write_data, mem_byte_en, ld_rdata} !== 83'd0) begin
        errors++;
        $display("FAIL reset_outputs: gnt=%b%b rv=%b rw=%b busy=%b addr=%h wd=%h be=%h rd=%h expected all 0",
                 ld_gnt, st_gnt, ld_rvalid, mem_rw_mode, busy, mem_addr, mem_write_data, mem_byte_en, ld_rdata);
      end
    end
    next_cycle();
    i_rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ld_gnt, st_gnt} !== 2'b00) begin
      errors++; $display("FAIL rst_cycle1: ld_gnt,st_gnt=%b expected 00", {ld_gnt, st_gnt});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({ld_gnt, st_gnt, mem_rw_mode, mem_addr, mem_byte_en} !== {3'b100, 10'h02A, 4'hF}) begin
      errors++;
      $display("FAIL rst_first_grant: ld_gnt=%b st_gnt=%b rw=%b addr=%h be=%h expected 1 0 0 02a f",
               ld_gnt, st_gnt, mem_rw_mode, mem_addr, mem_byte_en);
    end
    next_cycle();
    ld_req = 1'b0; st_req = 1'b0;
    wait_idle();
  endtask

  task automatic test_single_store();
    st_req = 1'b1; st_addr = 10'h012; st_wdata = 32'hA5A5_0000; st_byte_en = 4'b1100;
    @(negedge clk);
    checks++;
    if ({st_gnt, busy} !== 2'b00) begin
      errors++; $display("FAIL store_req_cycle: st_gnt,busy=%b expected 00", {st_gnt, busy});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({st_gnt, ld_gnt, busy} !== 3'b101) begin
      errors++; $display("FAIL store_gnt: st_gnt,ld_gnt,busy=%b expected 101", {st_gnt, ld_gnt, busy});
    end
    checks++;
    if ({mem_rw_mode, mem_addr, mem_write_data, mem_byte_en} !== {1'b1, 10'h012, 32'hA5A5_0000, 4'b1100}) begin
      errors++;
      $display("FAIL store_cmd: rw=%b addr=%h wd=%h be=%b expected 1 012 a5a50000 1100",
               mem_rw_mode, mem_addr, mem_write_data, mem_byte_en);
    end
    next_cycle();
    st_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, st_gnt, mem_rw_mode, mem_addr} !== 13'd0) begin
      errors++; $display("FAIL store_done: busy=%b st_gnt=%b rw=%b addr=%h expected 0 0 0 000",
                         busy, st_gnt, mem_rw_mode, mem_addr);
    end
    wait_idle();
  endtask

  task automatic test_single_load();
    store_raw(10'h3FF, 32'hDEAD_BEEF, 4'hF);
    ld_req = 1'b1; ld_addr = 10'h3FF;
    @(negedge clk);
    checks++;
    if (ld_gnt !== 1'b0) begin errors++; $display("FAIL load_req_cycle: ld_gnt=%b expected 0", ld_gnt); end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({ld_gnt, busy, ld_rvalid, mem_rw_mode, mem_addr, mem_byte_en} !== {4'b1100, 10'h3FF, 4'hF}) begin
      errors++; $display("FAIL load_issue: gnt=%b busy=%b rv=%b rw=%b addr=%h be=%h expected 1 1 0 0 3ff f",
                         ld_gnt, busy, ld_rvalid, mem_rw_mode, mem_addr, mem_byte_en);
    end
    next_cycle();
    ld_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({ld_rvalid, busy, mem_rw_mode, mem_addr, ld_rdata} !== {3'b010, 10'h3FF, 32'd0}) begin
      errors++; $display("FAIL load_wait: rv=%b busy=%b rw=%b addr=%h rd=%h expected 0 1 0 3ff 00000000",
                         ld_rvalid, busy, mem_rw_mode, mem_addr, ld_rdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({ld_rvalid, ld_rdata, mem_addr} !== {1'b1, 32'hDEAD_BEEF, 10'h3FF}) begin
      errors++; $display("FAIL load_return: rv=%b rd=%h addr=%h expected 1 deadbeef 3ff",
                         ld_rvalid, ld_rdata, mem_addr);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({ld_rvalid, busy, ld_rdata} !== 34'd0) begin
      errors++; $display("FAIL load_done: rv=%b busy=%b rd=%h expected 0 0 0", ld_rvalid, busy, ld_rdata);
    end
    wait_idle();
  endtask

  task automatic test_byte_en_zero();
    logic [31:0] d;
    st_req = 1'b1; st_addr = 10'h012; st_wdata = 32'hFFFF_FFFF; st_byte_en = 4'b0000;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({st_gnt, mem_rw_mode, mem_byte_en} !== 6'b110000) begin
      errors++; $display("FAIL store_be0: st_gnt=%b rw=%b be=%b expected 1 1 0000", st_gnt, mem_rw_mode, mem_byte_en);
    end
    next_cycle();
    st_req = 1'b0;
    wait_idle();
    load_raw(10'h012, d);
    checks++;
    if (d !== 32'hA5A5_0000) begin errors++; $display("FAIL be0_no_write: rdata=%h expected a5a50000", d); end
  endtask

  task automatic test_rr_contention();
    logic [3:0] order = 4'd0;
    int n = 0;
    do_reset(2);
    ld_req = 1'b1; st_req = 1'b1; ld_addr = 10'h040; st_addr = 10'h041;
    st_wdata = 32'h0000_0041; st_byte_en = 4'hF;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (ld_gnt && st_gnt) begin
        errors++; checks++; $display("FAIL rr_both_gnt: ld_gnt=1 st_gnt=1 expected at most one");
      end
      if (ld_gnt) begin order[n] = 1'b0; n++; end
      else if (st_gnt) begin order[n] = 1'b1; n++; end
      next_cycle();
    end
    ld_req = 1'b0; st_req = 1'b0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL rr_count: grants=%0d expected 4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (order[k] !== k[0]) begin
        errors++; $display("FAIL rr_order: grant %0d is_store=%b expected %b", k, order[k], k[0]);
      end
    end
    wait_idle();
  endtask

  task automatic test_fixed_priority();
    logic [3:0] order = 4'd0;
    logic [3:0] exp_order = 4'b0111;
    int n = 0;
    do_reset(2);
    ld_req = 1'b1; st_req = 1'b1; ld_addr = 10'h050; st_addr = 10'h051;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (fp_ld_gnt) begin order[n] = 1'b0; n++; end
      else if (fp_st_gnt) begin order[n] = 1'b1; n++; end
      next_cycle();
      if (n == 3) st_req = 1'b0;
    end
    ld_req = 1'b0; st_req = 1'b0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL fp_count: grants=%0d expected 4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (order[k] !== exp_order[k]) begin
        errors++; $display("FAIL fp_order: grant %0d is_store=%b expected %b", k, order[k], exp_order[k]);
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] d;
    bit ok = 1'b0;
    bit seen = 1'b0;
    ld_req = 1'b1; ld_addr = 10'h055;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ld_gnt) begin ok = 1'b1; break; end
      next_cycle();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_gnt: no ld_gnt within 20 cycles"); end
    next_cycle();
    ld_req = 1'b0;
    i_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ld_rvalid, ld_gnt} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_outputs: busy,rv,gnt=%b expected 000", {busy, ld_rvalid, ld_gnt});
    end
    next_cycle();
    next_cycle();
    i_rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen = seen | ld_rvalid | busy;
      next_cycle();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_mid_no_rvalid: rvalid/busy=1 after reset expected 0"); end
    store_raw(10'h055, 32'h1234_5678, 4'hF);
    load_raw(10'h055, d);
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL rst_mid_reload: rdata=%h expected 12345678", d); end
  endtask

  task automatic test_busy_request();
    bit ok = 1'b0;
    bit early = 1'b0;
    ld_req = 1'b1; ld_addr = 10'h100;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ld_gnt) begin ok = 1'b1; break; end
      next_cycle();
    end
    if (!ok) begin errors++; checks++; $display("FAIL busy_ld_gnt: no ld_gnt within 20 cycles"); end
    next_cycle();
    ld_req = 1'b0;
    st_req = 1'b1; st_addr = 10'h200; st_wdata = 32'h0BAD_F00D; st_byte_en = 4'hF;
    @(negedge clk);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (st_gnt) early = 1'b1;
      if (ld_rvalid) begin ok = 1'b1; break; end
      next_cycle();
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_rvalid: no ld_rvalid within 10 cycles"); end
    checks++;
    if (early) begin errors++; $display("FAIL busy_no_early_gnt: st_gnt=1 during load expected 0"); end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({st_gnt, busy} !== 2'b00) begin
      errors++; $display("FAIL busy_idle_gap: st_gnt,busy=%b expected 00", {st_gnt, busy});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({st_gnt, mem_rw_mode, mem_addr} !== {2'b11, 10'h200}) begin
      errors++; $display("FAIL busy_deferred_gnt: st_gnt=%b rw=%b addr=%h expected 1 1 200",
                         st_gnt, mem_rw_mode, mem_addr);
    end
    next_cycle();
    st_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_single_load();
    test_byte_en_zero();
    test_rr_contention();
    test_fixed_priority();
    test_reset_mid_load();
    test_busy_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
